// File: rtl/irq_timer_csr.sv
// irq_timer_csr: machine-mode periodic timer, interrupt CSRs and interrupt
// arbitration for the RV32 pipeline.
// Build option: define VECTORED_MODE_EN to support mtvec MODE=1 (vectored).
module irq_timer_csr #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] timer_limit,
  input  logic        external_int,
  input  logic        software_int,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        trap_allow,
  input  logic [31:0] epc_in,
  input  logic        mret,
  output logic        timer_int,
  output logic        irq_take,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic [31:0] counter;
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_msie;
  logic        mie_mtie;
  logic        mie_meie;
  logic [29:0] mtvec_base;
  logic [1:0]  mtvec_mode;
  logic        mtip;
  logic        meip;
  logic [29:0] mepc_hi;
  logic [31:0] mcause;

  logic [31:0] mip_val;
  logic [31:0] mie_val;
  logic [31:0] mepc_val;
  logic [31:0] mtvec_val;
  logic [31:0] pend;
  logic [3:0]  cause;
  logic [31:0] trap_target;
  logic        wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause, wr_mip;

  assign wr_mstatus = csr_we && (csr_addr == ADDR_MSTATUS);
  assign wr_mie     = csr_we && (csr_addr == ADDR_MIE);
  assign wr_mtvec   = csr_we && (csr_addr == ADDR_MTVEC);
  assign wr_mepc    = csr_we && (csr_addr == ADDR_MEPC);
  assign wr_mcause  = csr_we && (csr_addr == ADDR_MCAUSE);
  assign wr_mip     = csr_we && (csr_addr == ADDR_MIP);

  assign mip_val   = {20'd0, meip, 3'd0, mtip, 3'd0, software_int, 3'd0};
  assign mie_val   = {20'd0, mie_meie, 3'd0, mie_mtie, 3'd0, mie_msie, 3'd0};
  assign mepc_val  = {mepc_hi, 2'b00};
  assign mtvec_val = {mtvec_base, mtvec_mode};

  // Arbitration: pick highest-priority pending source and compute redirect.
  always_comb begin
    pend        = mip_val & mie_val;
    cause       = 4'd7;
    trap_target = {mtvec_base, 2'b00};
    irq_take    = trap_allow & mstatus_mie & (|pend) & ~mret;
    if (pend[11]) begin
      cause = 4'd11;
    end else if (pend[3]) begin
      cause = 4'd3;
    end else begin
      cause = 4'd7;
    end
`ifdef VECTORED_MODE_EN
    if (mtvec_mode == 2'b01) begin
      trap_target = {mtvec_base, 2'b00} + {26'd0, cause, 2'b00};
    end else begin
      trap_target = {mtvec_base, 2'b00};
    end
`endif
    if (irq_take) begin
      redirect_pc = trap_target;
    end else if (mret) begin
      redirect_pc = mepc_val;
    end else begin
      redirect_pc = 32'd0;
    end
  end

  // CSR read mux; unimplemented addresses read as zero.
  always_comb begin
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      ADDR_MIE:     csr_rdata = mie_val;
      ADDR_MTVEC:   csr_rdata = mtvec_val;
      ADDR_MEPC:    csr_rdata = mepc_val;
      ADDR_MCAUSE:  csr_rdata = mcause;
      ADDR_MIP:     csr_rdata = mip_val;
      default:      csr_rdata = 32'd0;
    endcase
  end

  // Periodic timer: wrap when the count reaches limit-1 (or beyond after a limit change).
  always_ff @(posedge clk) begin
    if (reset || (timer_limit == 32'd0)) begin
      counter   <= 32'd0;
      timer_int <= 1'b0;
    end else if (counter >= (timer_limit - 32'd1)) begin
      counter   <= 32'd0;
      timer_int <= 1'b1;
    end else begin
      counter   <= counter + 32'd1;
      timer_int <= 1'b0;
    end
  end

  // mstatus: trap entry beats mret, which beats a software write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (irq_take) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_mstatus) begin
      mstatus_mie  <= csr_wdata[3];
      mstatus_mpie <= csr_wdata[7];
    end else begin
      mstatus_mie  <= mstatus_mie;
      mstatus_mpie <= mstatus_mpie;
    end
  end

  // mie and mtvec: plain software-writable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mie_msie   <= 1'b0;
      mie_mtie   <= 1'b0;
      mie_meie   <= 1'b0;
      mtvec_base <= RESET_MTVEC[31:2];
    end else begin
      if (wr_mie) begin
        mie_msie <= csr_wdata[3];
        mie_mtie <= csr_wdata[7];
        mie_meie <= csr_wdata[11];
      end
      if (wr_mtvec) begin
        mtvec_base <= csr_wdata[31:2];
      end
    end
  end

`ifdef VECTORED_MODE_EN
  // mtvec MODE field, writable only in the vectored build.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtvec_mode <= RESET_MTVEC[1:0];
    end else if (wr_mtvec) begin
      mtvec_mode <= csr_wdata[1:0];
    end else begin
      mtvec_mode <= mtvec_mode;
    end
  end
`else
  assign mtvec_mode = 2'b00;
`endif

  // mepc / mcause: trap entry overrides a same-cycle software write.
  always_ff @(posedge clk) begin
    if (reset) begin
      mepc_hi <= 30'd0;
      mcause  <= 32'd0;
    end else if (irq_take) begin
      mepc_hi <= epc_in[31:2];
      mcause  <= {1'b1, 27'd0, cause};
    end else begin
      if (wr_mepc) begin
        mepc_hi <= csr_wdata[31:2];
      end
      if (wr_mcause) begin
        mcause <= csr_wdata;
      end
    end
  end

  // Pending latches: a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtip <= 1'b0;
      meip <= 1'b0;
    end else begin
      if (timer_int) begin
        mtip <= 1'b1;
      end else if ((irq_take && (cause == 4'd7)) || (wr_mip && !csr_wdata[7])) begin
        mtip <= 1'b0;
      end
      if (external_int) begin
        meip <= 1'b1;
      end else if ((irq_take && (cause == 4'd11)) || (wr_mip && !csr_wdata[11])) begin
        meip <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_timer_csr.sv
// Directed self-checking bench for irq_timer_csr.
module tb_irq_timer_csr;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] timer_limit;
  logic        external_int;
  logic        software_int;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        trap_allow;
  logic [31:0] epc_in;
  logic        mret;
  logic        timer_int;
  logic        irq_take;
  logic [31:0] redirect_pc;

  int checks = 0;
  int failures = 0;

`ifdef VECTORED_MODE_EN
  localparam logic        VEC = 1'b1;
`else
  localparam logic        VEC = 1'b0;
`endif
  localparam logic [31:0] MTVEC_RB = VEC ? 32'h0000_0101 : 32'h0000_0100;

  irq_timer_csr dut (
    .clk(clk), .reset(reset), .timer_limit(timer_limit),
    .external_int(external_int), .software_int(software_int),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .trap_allow(trap_allow), .epc_in(epc_in),
    .mret(mret), .timer_int(timer_int), .irq_take(irq_take),
    .redirect_pc(redirect_pc)
  );

  always #10 clk = ~clk;

  // Expected interrupt redirect with mtvec written to 0x101.
  function automatic logic [31:0] exp_redir(input int c);
    return VEC ? (32'h0000_0100 + 32'(4 * c)) : 32'h0000_0100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  initial begin
    int n;
    bit found;
    reset = 1'b1; timer_limit = 32'd0; external_int = 1'b0; software_int = 1'b0;
    csr_we = 1'b0; csr_addr = 12'h000; csr_wdata = 32'd0; trap_allow = 1'b0;
    epc_in = 32'd0; mret = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_timer_int", {31'd0, timer_int}, 32'd0);
    chk("rst_irq_take", {31'd0, irq_take}, 32'd0);
    chk("idle_redirect", redirect_pc, 32'd0);
    rd("rst_mstatus", 12'h300, 32'd0);
    rd("rst_mie", 12'h304, 32'd0);
    rd("rst_mtvec", 12'h305, 32'h0000_0100);
    rd("rst_mepc", 12'h341, 32'd0);
    rd("rst_mcause", 12'h342, 32'd0);
    rd("rst_mip", 12'h344, 32'd0);

    // CSR field masking
    wr(12'h300, 32'hFFFF_FFFF); rd("mstatus_mask", 12'h300, 32'h0000_0088);
    wr(12'h300, 32'd0);
    wr(12'h304, 32'hFFFF_FFFF); rd("mie_mask", 12'h304, 32'h0000_0888);
    wr(12'h304, 32'd0);
    wr(12'h341, 32'h0000_0123); rd("mepc_align", 12'h341, 32'h0000_0120);
    wr(12'h342, 32'hDEAD_BEEF); rd("mcause_rw", 12'h342, 32'hDEAD_BEEF);
    wr(12'h342, 32'd0);
    wr(12'h305, 32'h0000_0101); rd("mtvec_mode", 12'h305, MTVEC_RB);
    wr(12'h7C0, 32'h0000_0005); rd("unimpl_zero", 12'h7C0, 32'd0);
    software_int = 1'b1; rd("mip_msip", 12'h344, 32'h0000_0008);
    software_int = 1'b0;

    // Timer period 100
    timer_limit = 32'd100;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (timer_int) begin n = i; found = 1'b1; break; end
    end
    chk("tick1_found", {31'd0, found}, 32'd1);
    chk("tick1_latency", n, 32'd100);
    tick();
    chk("tick_one_cycle", {31'd0, timer_int}, 32'd0);
    rd("mip_after_tick", 12'h344, 32'h0000_0080);
    chk("no_take_mie0", {31'd0, irq_take}, 32'd0);
    n = 0; found = 1'b0;
    for (int i = 2; i <= 300; i++) begin
      tick();
      if (timer_int) begin n = i; found = 1'b1; break; end
    end
    chk("tick2_found", {31'd0, found}, 32'd1);
    chk("tick_period", n, 32'd100);
    tick();

    // mip writes: 1s ignored, 0s clear
    wr(12'h344, 32'h0000_0888); rd("mip_w1_ignored", 12'h344, 32'h0000_0080);
    wr(12'h344, 32'd0); rd("mip_w0_clear", 12'h344, 32'd0);

    // Timer trap, with a competing mepc write every cycle
    timer_limit = 32'd10;
    wr(12'h300, 32'h0000_0008);
    wr(12'h304, 32'h0000_0080);
    trap_allow = 1'b1; epc_in = 32'h0000_0040;
    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h0000_0998;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (irq_take) begin found = 1'b1; break; end
      tick();
    end
    chk("timer_take", {31'd0, found}, 32'd1);
    chk("timer_redirect", redirect_pc, exp_redir(7));
    tick();
    csr_we = 1'b0; trap_allow = 1'b0; timer_limit = 32'd0;
    rd("timer_mcause", 12'h342, 32'h8000_0007);
    rd("timer_mepc", 12'h341, 32'h0000_0040);
    rd("timer_mstatus", 12'h300, 32'h0000_0080);
    rd("timer_mip_clr", 12'h344, 32'd0);

    // External pulse while MIE=0 stays pending
    wr(12'h304, 32'h0000_0880);
    trap_allow = 1'b1; epc_in = 32'h0000_0044;
    external_int = 1'b1; tick(); tick(); external_int = 1'b0;
    #1;
    chk("ext_gated", {31'd0, irq_take}, 32'd0);
    rd("ext_pending", 12'h344, 32'h0000_0800);
    wr(12'h300, 32'h0000_0008);
    #1;
    chk("ext_take", {31'd0, irq_take}, 32'd1);
    chk("ext_redirect", redirect_pc, exp_redir(11));
    tick();
    trap_allow = 1'b0;
    rd("ext_mcause", 12'h342, 32'h8000_000B);
    rd("ext_mepc", 12'h341, 32'h0000_0044);
    rd("ext_mip_clr", 12'h344, 32'd0);

    // MEIP and MTIP together: cause 11 first, then 7 after mret
    wr(12'h300, 32'h0000_0008);
    external_int = 1'b1; timer_limit = 32'd3;
    tick();
    external_int = 1'b0;
    found = 1'b0;
    csr_addr = 12'h344;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (csr_rdata == 32'h0000_0880) begin found = 1'b1; break; end
      tick();
    end
    chk("both_pending", {31'd0, found}, 32'd1);
    timer_limit = 32'd0;
    trap_allow = 1'b1; epc_in = 32'h0000_0048;
    #1;
    chk("both_take", {31'd0, irq_take}, 32'd1);
    chk("both_redirect11", redirect_pc, exp_redir(11));
    tick();
    rd("both_mcause11", 12'h342, 32'h8000_000B);
    mret = 1'b1;
    #1;
    chk("mret_redirect", redirect_pc, 32'h0000_0048);
    chk("mret_no_take", {31'd0, irq_take}, 32'd0);
    tick();
    mret = 1'b0; epc_in = 32'h0000_004C;
    rd("mret_mstatus", 12'h300, 32'h0000_0088);
    chk("mti_take", {31'd0, irq_take}, 32'd1);
    chk("mti_redirect", redirect_pc, exp_redir(7));
    tick();
    trap_allow = 1'b0;
    rd("mti_mcause", 12'h342, 32'h8000_0007);
    rd("mti_mepc", 12'h341, 32'h0000_004C);

    // mret blocks a pending interrupt while MIE=1
    wr(12'h304, 32'h0000_0888);
    software_int = 1'b1;
    wr(12'h300, 32'h0000_0088);
    trap_allow = 1'b1; mret = 1'b1; epc_in = 32'h0000_0050;
    #1;
    chk("mret_blocks", {31'd0, irq_take}, 32'd0);
    chk("mret_blk_redir", redirect_pc, 32'h0000_004C);
    tick();
    mret = 1'b0;
    #1;
    chk("msi_take", {31'd0, irq_take}, 32'd1);
    chk("msi_redirect", redirect_pc, exp_redir(3));
    tick();
    trap_allow = 1'b0;
    rd("msi_mcause", 12'h342, 32'h8000_0003);
    rd("msi_not_clr", 12'h344, 32'h0000_0008);

    // Reset during a trap
    wr(12'h300, 32'h0000_0088);
    trap_allow = 1'b1; epc_in = 32'h0000_0060; reset = 1'b1;
    tick();
    reset = 1'b0; trap_allow = 1'b0; software_int = 1'b0;
    rd("rst2_mstatus", 12'h300, 32'd0);
    rd("rst2_mepc", 12'h341, 32'd0);
    rd("rst2_mcause", 12'h342, 32'd0);
    rd("rst2_mtvec", 12'h305, 32'h0000_0100);
    rd("rst2_mip", 12'h344, 32'd0);

    // Lowering the limit below the running count wraps on the next edge
    timer_limit = 32'd100;
    repeat (50) tick();
    timer_limit = 32'd10;
    tick();
    chk("limit_shrink_wrap", {31'd0, timer_int}, 32'd1);
    timer_limit = 32'd0;
    tick();
    chk("limit_zero", {31'd0, timer_int}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
